// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if
//   Bundles every non-clock/reset signal of serial_add_ctrl.
//   Handshakes (both directions use the same rule):
//     a transfer happens on a rising CLK edge where VALID and READY are both 1;
//     the controller raises IN_READY only in IDLE and OUT_VALID only in HOLD,
//     and neither depends combinationally on the partner's VALID/READY.
//   Ports (from the controller's side, modport slave):
//     IN_VALID/IN_READY/OPA/OPB     operand request channel
//     OUT_VALID/OUT_READY/RESULT/CARRY  result channel
//     BUSY                          high in every state except IDLE
//     SA_CLR_N/SA_A/SA_B            drive the bit-serial adder
//     SA_SUM/SA_COUT                registered outputs of the adder
//     DBG_STATE                     current controller state encoding
//   modport master is the requester/adder side.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] OPA;
    logic [WIDTH-1:0] OPB;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] RESULT;
    logic             CARRY;
    logic             BUSY;
    logic             SA_CLR_N;
    logic             SA_A;
    logic             SA_B;
    logic             SA_SUM;
    logic             SA_COUT;
    logic [2:0]       DBG_STATE;

    modport slave (
        input  IN_VALID, OPA, OPB, OUT_READY, SA_SUM, SA_COUT,
        output IN_READY, OUT_VALID, RESULT, CARRY, BUSY,
               SA_CLR_N, SA_A, SA_B, DBG_STATE
    );

    modport master (
        output IN_VALID, OPA, OPB, OUT_READY, SA_SUM, SA_COUT,
        input  IN_READY, OUT_VALID, RESULT, CARRY, BUSY,
               SA_CLR_N, SA_A, SA_B, DBG_STATE
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Sequencer for a bit-serial adder (1-bit full adder, registered SUM/COUT,
//   async active-low clear). Accepts a WIDTH-bit operand pair, clears the
//   adder carry for one cycle, streams the operands LSB-first, collects the
//   registered sum stream and presents {CARRY,RESULT} = OPA+OPB.
//   States: IDLE -> CLEAR (1) -> SHIFT (WIDTH) -> DRAIN (1) -> HOLD.
//   Ports:
//     CLK  rising-edge clock
//     RST  asynchronous, active-low reset
//     bus  serial_add_ctrl_if.slave (handshakes, result, adder link, debug)
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] sr_a, sr_b;
    // Holds sum bits 0..WIDTH-2; bit WIDTH-1 arrives directly in DRAIN.
    logic [WIDTH-2:0] sr_sum;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             clr_n_q;
    logic [CW-1:0]    cnt;

    logic accept;
    logic last_bit;
    logic in_ready, out_valid, busy, sa_a, sa_b;

    assign accept   = (state == S_IDLE) && bus.IN_VALID;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.IN_VALID) state_nx = S_CLEAR;
            S_CLEAR: state_nx = S_SHIFT;
            S_SHIFT: if (last_bit) state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_HOLD;
            S_HOLD:  if (bus.OUT_READY) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        sa_a      = 1'b0;
        sa_b      = 1'b0;
        case (state)
            S_IDLE: begin
                busy     = 1'b0;
                // Stays low while RST is held, even though state reads IDLE.
                in_ready = RST;
            end
            S_SHIFT: begin
                sa_a = sr_a[0];
                sa_b = sr_b[0];
            end
            S_HOLD:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sr_a     <= '0;
            sr_b     <= '0;
            sr_sum   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cnt      <= '0;
            // Keeps the adder cleared together with the controller.
            clr_n_q  <= 1'b0;
        end else begin
            // Registered clear: low exactly during the CLEAR cycle.
            clr_n_q <= !accept;
            if (accept) begin
                sr_a <= bus.OPA;
                sr_b <= bus.OPB;
                cnt  <= '0;
            end
            if (state == S_SHIFT) begin
                sr_a <= sr_a >> 1;
                sr_b <= sr_b >> 1;
                cnt  <= cnt + CW'(1);
                // Adder output lags by one cycle: at k>=1 it carries sum bit k-1.
                if (cnt != '0)
                    sr_sum <= (WIDTH-1)'({bus.SA_SUM, sr_sum} >> 1);
            end
            if (state == S_DRAIN) begin
                result_q <= {bus.SA_SUM, sr_sum};
                carry_q  <= bus.SA_COUT;
            end
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid;
    assign bus.BUSY      = busy;
    assign bus.SA_A      = sa_a;
    assign bus.SA_B      = sa_b;
    assign bus.SA_CLR_N  = clr_n_q;
    assign bus.RESULT    = result_q;
    assign bus.CARRY     = carry_q;
    assign bus.DBG_STATE = state;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Bench for serial_add_ctrl (WIDTH=8) with a behavioural bit-serial adder.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_add_ctrl;
    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Bit-serial adder: registered sum/carry, async active-low clear.
    logic sa_sum_q  = 1'b0;
    logic sa_cout_q = 1'b0;
    always @(posedge CLK or negedge bus.SA_CLR_N) begin
        if (!bus.SA_CLR_N) begin
            sa_sum_q  <= 1'b0;
            sa_cout_q <= 1'b0;
        end else begin
            {sa_cout_q, sa_sum_q} <= 2'(bus.SA_A) + 2'(bus.SA_B) + 2'(sa_cout_q);
        end
    end
    assign bus.SA_SUM  = sa_sum_q;
    assign bus.SA_COUT = sa_cout_q;

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [W:0] exp_q[$];
    logic [W:0] last_out = '0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         c;
        int           hold;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One operation; rst_at >= 0 asserts reset in cycle j=rst_at after accept.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ec,
                          input int hold, input int rst_at);
        int n;
        int j;
        int clr_low;
        logic [W-1:0] sa_stream;
        logic [W:0] e;
        n = 0;
        while (!bus.IN_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("ready_wait", n < 50, 1);
        bus.OPA       = a;
        bus.OPB       = b;
        bus.IN_VALID  = 1'b1;
        bus.OUT_READY = (hold == 0);
        exp_q.push_back({ec, er});
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        bus.OPA      = ~a;
        bus.OPB      = W'($urandom_range(0, 255));
        j = 0;
        clr_low = 0;
        sa_stream = '0;
        while (!bus.OUT_VALID && j < 40) begin
            if (!bus.SA_CLR_N) begin
                clr_low++;
                check("clr_low_position", j, 0);
            end
            if (j >= 1 && j <= W) sa_stream[j-1] = bus.SA_A;
            if (j == 0) begin
                check("busy_clear", bus.BUSY, 1);
                check("in_ready_busy", bus.IN_READY, 0);
                check("sa_a_in_clear", bus.SA_A, 0);
                check("stale_result_kept", {bus.CARRY, bus.RESULT}, last_out);
            end
            if (j == 1) check("state_shift", bus.DBG_STATE, 2);
            if (j == rst_at) begin
                RST = 1'b0;
                #1;
                check("rst_out_valid", bus.OUT_VALID, 0);
                check("rst_busy", bus.BUSY, 0);
                check("rst_in_ready", bus.IN_READY, 0);
                check("rst_sa_clr_n", bus.SA_CLR_N, 0);
                check("rst_result", {bus.CARRY, bus.RESULT}, 0);
                check("rst_sa_a", bus.SA_A, 0);
                check("rst_state", bus.DBG_STATE, 0);
                exp_q.delete();
                last_out = '0;
                repeat (2) @(negedge CLK);
                RST = 1'b1;
                @(negedge CLK);
                check("rel_sa_clr_n", bus.SA_CLR_N, 1);
                check("rel_in_ready", bus.IN_READY, 1);
                check("rel_no_output", bus.OUT_VALID, 0);
                return;
            end
            @(negedge CLK);
            j++;
        end
        check("latency", j, W + 2);
        check("sa_a_stream", sa_stream, a);
        check("clr_low_cycles", clr_low, 1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            e = {ec, er};
        end else begin
            e = exp_q.pop_front();
        end
        check("result", bus.RESULT, e[W-1:0]);
        check("carry", bus.CARRY, e[W]);
        last_out = e;
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", bus.OUT_VALID, 1);
            check("hold_stable", {bus.CARRY, bus.RESULT}, e);
            check("hold_in_ready", bus.IN_READY, 0);
            bus.IN_VALID = 1'b1;
            @(negedge CLK);
        end
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        @(negedge CLK);
        check("valid_dropped", bus.OUT_VALID, 0);
        check("back_to_idle", bus.IN_READY, 1);
        check("result_after_take", {bus.CARRY, bus.RESULT}, e);
        bus.OUT_READY = 1'b0;
    endtask

    // Back-to-back with IN_VALID and OUT_READY held high.
    task automatic run_b2b();
        int cyc;
        int nacc;
        int nout;
        int acc[2];
        bit changed;
        logic [W:0] e;
        cyc = 0;
        nacc = 0;
        nout = 0;
        changed = 0;
        acc[0] = 0;
        acc[1] = 0;
        bus.OUT_READY = 1'b1;
        bus.IN_VALID  = 1'b1;
        bus.OPA       = 8'h80;
        bus.OPB       = 8'h80;
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b0, 8'h80});
        while ((nacc < 2 || nout < 2) && cyc < 100) begin
            if (nacc == 1 && !changed) begin
                bus.OPA = 8'h7F;
                bus.OPB = 8'h01;
                changed = 1;
            end
            if (nacc == 2) bus.IN_VALID = 1'b0;
            if (bus.OUT_VALID) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                check("b2b_result", bus.RESULT, e[W-1:0]);
                check("b2b_carry", bus.CARRY, e[W]);
                last_out = e;
                nout++;
            end
            if (bus.IN_READY && bus.IN_VALID && nacc < 2) begin
                acc[nacc] = cyc;
                nacc++;
            end
            @(negedge CLK);
            cyc++;
        end
        check("b2b_accepts", nacc, 2);
        check("b2b_outputs", nout, 2);
        check("b2b_interval", acc[1] - acc[0], W + 4);
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{8'h5A, 8'h3C, 8'h96, 1'b0, 0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 0};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 5};
        vecs[4] = '{8'hA5, 8'h5A, 8'hFF, 1'b0, 0};
        vecs[5] = '{8'hC3, 8'h7E, 8'h41, 1'b1, 2};

        bus.IN_VALID  = 1'b0;
        bus.OPA       = '0;
        bus.OPB       = '0;
        bus.OUT_READY = 1'b0;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_in_ready", bus.IN_READY, 0);
        check("reset_out_valid", bus.OUT_VALID, 0);
        check("reset_busy", bus.BUSY, 0);
        check("reset_sa_clr_n", bus.SA_CLR_N, 0);
        check("reset_result", {bus.CARRY, bus.RESULT}, 0);
        RST = 1'b1;
        @(negedge CLK);
        check("release_sa_clr_n", bus.SA_CLR_N, 1);
        check("release_in_ready", bus.IN_READY, 1);

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].c, vecs[i].hold, -1);

        // Reset during SHIFT k=4 (cycle j=5 after accept), then a fresh op.
        run_op(8'h55, 8'h0F, 8'h64, 1'b0, 0, 5);
        run_op(8'h12, 8'h34, 8'h46, 1'b0, 0, -1);

        run_b2b();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
